// File: rtl/result_regfile_wb.sv
// rtl/result_regfile_wb.sv - result bank that captures SIMD result columns and drains them as a word stream
// One bank alternates between column capture and word drain.
module result_regfile_wb #(
   parameter int N    = 16,
   parameter int COLS = 16
) (
   input  logic                         CLK,
   input  logic                         RSTN,
   input  logic                         RES_VALID,
   output logic                         RES_READY,
   input  logic [N-1:0][31:0]           RES_DATA,
   input  logic                         ABORT,
   output logic                         OUT_VALID,
   input  logic                         OUT_READY,
   output logic [31:0]                  OUT_DATA,
   output logic                         OUT_LAST,
   output logic [$clog2(COLS+1)-1:0]    COL_CNT,
   output logic                         DONE
);

   localparam int DEPTH = N * COLS;
   localparam int CW    = $clog2(COLS);
   localparam int AW    = $clog2(DEPTH);
   localparam int NW    = $clog2(COLS + 1);

   typedef enum logic {
      COLLECT = 1'b0,
      DRAIN   = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   col_q, col_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [NW-1:0]   col_cnt_q, col_cnt_d;
   logic            done_q, done_d;
   logic [31:0]     bank_q [DEPTH];
   logic [31:0]     bank_d [DEPTH];
   logic [AW-1:0]   wr_idx;

   logic            capture;
   logic            transfer;
   logic            last_col;
   logic            last_word;

   // Handshake outputs are held low while reset is asserted, independent of flop state.
   assign RES_READY = (state_q == COLLECT) && RSTN;
   assign OUT_VALID = (state_q == DRAIN) && RSTN;
   assign OUT_DATA  = bank_q[rd_q];
   assign last_word = (rd_q == AW'(DEPTH - 1));
   assign OUT_LAST  = OUT_VALID && last_word;
   assign COL_CNT   = col_cnt_q;
   assign DONE      = done_q;

   assign capture   = RES_VALID && RES_READY;
   assign transfer  = OUT_VALID && OUT_READY;
   assign last_col  = (col_q == CW'(COLS - 1));

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      rd_d      = rd_q;
      col_cnt_d = col_cnt_q;
      done_d    = 1'b0;
      bank_d    = bank_q;
      wr_idx    = '0;
      if (ABORT) begin
         // Abort wins over any same-cycle capture or transfer; bank is kept.
         state_d   = COLLECT;
         col_d     = '0;
         rd_d      = '0;
         col_cnt_d = '0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (capture) begin
                  for (int l = 0; l < N; l++) begin
                     wr_idx         = AW'(int'(col_q) * N + l);
                     bank_d[wr_idx] = RES_DATA[l];
                  end
                  if (last_col) begin
                     col_d     = '0;
                     rd_d      = '0;
                     col_cnt_d = NW'(COLS);
                     state_d   = DRAIN;
                  end else begin
                     col_d     = col_q + 1'b1;
                     col_cnt_d = col_cnt_q + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (transfer) begin
                  if (last_word) begin
                     rd_d      = '0;
                     col_cnt_d = '0;
                     done_d    = 1'b1;
                     state_d   = COLLECT;
                  end else begin
                     rd_d = rd_q + 1'b1;
                  end
               end
            end
            default: state_d = COLLECT;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q   <= COLLECT;
         col_q     <= '0;
         rd_q      <= '0;
         col_cnt_q <= '0;
         done_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            bank_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         rd_q      <= rd_d;
         col_cnt_q <= col_cnt_d;
         done_q    <= done_d;
         bank_q    <= bank_d;
      end
   end

endmodule

// File: tb/tb_result_regfile_wb.sv
// tb/tb_result_regfile_wb.sv - self-checking bench for result_regfile_wb against a queue-based frame model
// The model treats a captured frame as a queue of pending words.
module tb_result_regfile_wb;

   localparam int N    = 16;
   localparam int COLS = 16;
   localparam int W    = N * COLS;

   logic                      CLK = 1'b0;
   logic                      RSTN = 1'b0;
   logic                      RES_VALID = 1'b0;
   logic                      RES_READY;
   logic [N-1:0][31:0]        RES_DATA = '0;
   logic                      ABORT = 1'b0;
   logic                      OUT_VALID;
   logic                      OUT_READY = 1'b0;
   logic [31:0]               OUT_DATA;
   logic                      OUT_LAST;
   logic [$clog2(COLS+1)-1:0] COL_CNT;
   logic                      DONE;

   always #5 CLK = ~CLK;

   result_regfile_wb #(.N(N), .COLS(COLS)) dut (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .RES_VALID (RES_VALID),
      .RES_READY (RES_READY),
      .RES_DATA  (RES_DATA),
      .ABORT     (ABORT),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_DATA  (OUT_DATA),
      .OUT_LAST  (OUT_LAST),
      .COL_CNT   (COL_CNT),
      .DONE      (DONE)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_bank [W];
   int          m_cols   = 0;
   logic [31:0] m_q [$];
   bit          m_done   = 1'b0;
   int          m_frames = 0;
   int          m_pops   = 0;
   bit          prev_rst = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0][31:0] coldata(input int base, input int c);
      logic [N-1:0][31:0] r;
      for (int l = 0; l < N; l++) r[l] = 32'(base + c * N + l);
      return r;
   endfunction

   // One clock: drive inputs, check outputs against the model, advance the model, then take the edge.
   task automatic cycle(input bit rv, input logic [N-1:0][31:0] d, input bit ordy, input bit ab, input bit rst);
      bit pending;
      RES_VALID = rv;
      RES_DATA  = d;
      OUT_READY = ordy;
      ABORT     = ab;
      RSTN      = !rst;
      #1;
      pending = (m_q.size() > 0);
      if (rst) begin
         chk("rst_res_ready", 32'(RES_READY), 32'd0);
         chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
         chk("rst_out_last",  32'(OUT_LAST),  32'd0);
         if (prev_rst) begin
            chk("rst_col_cnt", 32'(COL_CNT), 32'd0);
            chk("rst_done",    32'(DONE),    32'd0);
         end
      end else begin
         chk("res_ready", 32'(RES_READY), 32'(!pending));
         chk("out_valid", 32'(OUT_VALID), 32'(pending));
         if (pending) chk("out_data", OUT_DATA, m_q[0]);
         chk("out_last",  32'(OUT_LAST), 32'(m_q.size() == 1));
         chk("col_cnt",   32'(COL_CNT),  pending ? 32'(COLS) : 32'(m_cols));
         chk("done",      32'(DONE),     32'(m_done));
      end
      if (rst) begin
         for (int k = 0; k < W; k++) m_bank[k] = '0;
         m_cols = 0;
         m_q.delete();
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (ab) begin
            m_cols = 0;
            m_q.delete();
         end else if (!pending) begin
            if (rv) begin
               for (int l = 0; l < N; l++) m_bank[m_cols * N + l] = d[l];
               m_cols++;
               if (m_cols == COLS) begin
                  for (int k = 0; k < W; k++) m_q.push_back(m_bank[k]);
                  m_cols = 0;
               end
            end
         end else if (ordy) begin
            void'(m_q.pop_front());
            m_pops++;
            if (m_q.size() == 0) begin
               m_done = 1'b1;
               m_frames++;
            end
         end
      end
      prev_rst = rst;
      @(posedge CLK);
      #1;
   endtask

   // rv_mode: 0 always, 1 every other cycle, 2 random; ordy_mode: 0 always, 1 pattern 1,0,0,1, 2 random.
   task automatic run_frame(input int base, input int rv_mode, input int ordy_mode, input bit rand_data,
                            input bit rand_abort, input int stop_pops, input int max_cyc);
      int                 start_f;
      int                 start_p;
      int                 cyc;
      bit                 rv;
      bit                 ordy;
      bit                 ab;
      logic [N-1:0][31:0] d;
      start_f = m_frames;
      start_p = m_pops;
      cyc     = 0;
      while (m_frames == start_f && (stop_pops == 0 || m_pops - start_p < stop_pops) && cyc < max_cyc) begin
         if (m_q.size() == 0) begin
            case (rv_mode)
               0:       rv = 1'b1;
               1:       rv = (cyc % 2 == 0);
               default: rv = ($urandom_range(0, 1) == 1);
            endcase
            for (int l = 0; l < N; l++) d[l] = rand_data ? 32'($urandom) : 32'(base + m_cols * N + l);
         end else begin
            rv = 1'b1;
            d  = {N{32'hDEADBEEF}};
         end
         case (ordy_mode)
            0:       ordy = 1'b1;
            1:       ordy = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: ordy = ($urandom_range(0, 3) != 0);
         endcase
         ab = rand_abort && ($urandom_range(0, 299) == 0);
         cycle(rv, d, ordy, ab, 1'b0);
         cyc++;
      end
      chk("frame_timeout", 32'(cyc < max_cyc), 32'd1);
   endtask

   initial begin
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, '0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

      run_frame(0, 0, 0, 1'b0, 1'b0, 0, 2000);
      run_frame(5000, 0, 0, 1'b0, 1'b0, 0, 2000);
      run_frame(0, 1, 1, 1'b0, 1'b0, 0, 3000);

      for (int i = 0; i < 5; i++) cycle(1'b1, coldata(700, i), 1'b1, 1'b0, 1'b0);
      cycle(1'b1, coldata(700, 5), 1'b1, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      run_frame(1000, 0, 0, 1'b0, 1'b0, 0, 2000);

      run_frame(2000, 0, 0, 1'b0, 1'b0, 100, 2000);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, '0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      run_frame(3000, 0, 0, 1'b0, 1'b0, 0, 2000);

      repeat (4) run_frame(0, 2, 2, 1'b1, 1'b1, 0, 4000);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
